// File: rtl/aes_uart_pkg.sv
// Shared definitions for the AES UART block shifters.
// Block geometry, FSM encoding and idle-timer sizing.
package aes_uart_pkg;

  localparam int BLOCK_BYTES = 16;
  localparam int BLOCK_W     = 128;

  typedef enum logic {
    COLLECT = 1'b0,
    PUSH    = 1'b1
  } shift_state_t;

  // Idle counter width: at least 20 bits, more if the limit needs it.
  function automatic int idle_w(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    return (w < 20) ? 20 : w;
  endfunction

endpackage

// File: rtl/idle_timer.sv
// Idle-cycle timer for partial blocks.
// Pulses expired on the cycle the count reaches the limit.
module idle_timer
  import aes_uart_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int IW = idle_w(TIMEOUT_CYCLES);
  localparam logic [IW-1:0] SAT = IW'(TIMEOUT_CYCLES);
  localparam logic [IW-1:0] LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : IW'(TIMEOUT_CYCLES - 1);

  logic [IW-1:0] idle_q;

  // Count enabled idle cycles, saturating at the limit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_q <= '0;
    end else if (clear) begin
      idle_q <= '0;
    end else if (enable && idle_q != SAT) begin
      idle_q <= idle_q + IW'(1);
    end
  end

  assign expired = (TIMEOUT_CYCLES != 0) && enable && (idle_q == LAST);

endmodule

// File: rtl/rx_shift.sv
// Assembles received UART bytes into 128-bit blocks.
// Pushes full blocks to the FIFO; drops bytes while blocked.
module rx_shift
  import aes_uart_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx_done,
  input  logic [7:0]         rx_data,
  input  logic               buffer_full,
  output logic               buffer_write,
  output logic [BLOCK_W-1:0] dout,
  output logic               shift_done,
  output logic               timeout,
  output logic               overflow
);

  shift_state_t state_q, state_d;

  logic [3:0]         cnt_q;
  logic [BLOCK_W-1:0] data_q;
  logic               accept;
  logic               drop;
  logic               push;
  logic               idle_en;
  logic               idle_clr;
  logic               expired;

  // Next state and per-cycle actions.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    drop    = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      COLLECT: begin
        accept = rx_done;
        if (rx_done && cnt_q == 4'(BLOCK_BYTES - 1))
          state_d = PUSH;
      end
      PUSH: begin
        drop = rx_done;
        push = !buffer_full;
        if (!buffer_full)
          state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  assign idle_en  = (state_q == COLLECT) && (cnt_q != 4'd0) && !rx_done;
  assign idle_clr = rx_done || (cnt_q == 4'd0);

  idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle (
    .clk    (clk),
    .reset  (reset),
    .clear  (idle_clr),
    .enable (idle_en),
    .expired(expired)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state_q <= COLLECT;
    else
      state_q <= state_d;
  end

  // Shift register, byte count and registered strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q        <= '0;
      data_q       <= '0;
      buffer_write <= 1'b0;
      shift_done   <= 1'b0;
      timeout      <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      buffer_write <= push;
      shift_done   <= push;
      timeout      <= 1'b0;
      if (drop)
        overflow <= 1'b1;
      unique case (1'b1)
        accept: begin
          data_q <= {data_q[BLOCK_W-9:0], rx_data};
          cnt_q  <= cnt_q + 4'd1;
        end
        expired: begin
          data_q  <= '0;
          cnt_q   <= '0;
          timeout <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign dout = data_q;

endmodule

// File: tb/tb_rx_shift.sv
// Directed and random checks of rx_shift.
// Reference model works on byte queues and block packing.
module tb_rx_shift;

  localparam int T = 20;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         rx_done = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         buffer_full = 1'b0;
  logic         buffer_write;
  logic [127:0] dout;
  logic         shift_done;
  logic         timeout;
  logic         overflow;

  rx_shift #(.TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_done     (rx_done),
    .rx_data     (rx_data),
    .buffer_full (buffer_full),
    .buffer_write(buffer_write),
    .dout        (dout),
    .shift_done  (shift_done),
    .timeout     (timeout),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]   q[$];
  logic [127:0] blk;
  bit           pending;
  int           idle;
  bit           m_ovf;
  bit           e_wr;
  bit           e_to;
  int           dut_wr = 0;
  int           dut_to = 0;
  logic [127:0] last_wr_dout = '0;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    blk = '0;
    pending = 0;
    idle = 0;
    m_ovf = 0;
    e_wr = 0;
    e_to = 0;
  endtask

  task automatic step(input bit rd, input logic [7:0] b, input bit bf);
    rx_done = rd;
    rx_data = b;
    buffer_full = bf;
    @(posedge clk);
    e_wr = 0;
    e_to = 0;
    if (pending) begin
      if (rd) m_ovf = 1;
      if (!bf) begin
        e_wr = 1;
        pending = 0;
      end
    end else if (rd) begin
      q.push_back(b);
      idle = 0;
      if (q.size() == 16) begin
        for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = q[i];
        q.delete();
        pending = 1;
      end
    end else if (q.size() > 0) begin
      idle++;
      if (idle == T) begin
        q.delete();
        idle = 0;
        e_to = 1;
      end
    end else begin
      idle = 0;
    end
    #1;
    chk("buffer_write", {127'd0, buffer_write}, {127'd0, e_wr});
    chk("shift_done", {127'd0, shift_done}, {127'd0, e_wr});
    chk("timeout", {127'd0, timeout}, {127'd0, e_to});
    chk("overflow", {127'd0, overflow}, {127'd0, m_ovf});
    if (e_wr) chk("dout", dout, blk);
    if (buffer_write) begin
      dut_wr++;
      last_wr_dout = dout;
    end
    if (timeout) dut_to++;
    rx_done = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) step(1, first + 8'(i), 0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_bw"}, {127'd0, buffer_write}, 128'd0);
    chk({tag, "_sd"}, {127'd0, shift_done}, 128'd0);
    chk({tag, "_to"}, {127'd0, timeout}, 128'd0);
    chk({tag, "_ovf"}, {127'd0, overflow}, 128'd0);
    chk({tag, "_dout"}, dout, 128'd0);
  endtask

  int w0;
  int t0;
  int p;

  initial begin
    model_reset();
    #1;
    chk_reset_outs("reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Block 00..0F
    w0 = dut_wr;
    send_seq(8'h00, 16);
    step(0, 8'h00, 0);
    step(0, 8'h00, 0);
    chk("r031_writes", 128'(dut_wr - w0), 128'd1);
    chk("r031_dout", last_wr_dout,
        128'h000102030405060708090A0B0C0D0E0F);

    // Backpressure for 50 cycles
    for (int i = 0; i < 16; i++) step(1, 8'($urandom_range(0, 255)), 0);
    w0 = dut_wr;
    repeat (50) step(0, 8'h00, 1);
    chk("r032_no_early", 128'(dut_wr - w0), 128'd0);
    step(0, 8'h00, 0);
    chk("r032_release", {127'd0, buffer_write}, 128'd1);

    // Byte while blocked is dropped
    for (int i = 0; i < 16; i++) step(1, 8'($urandom_range(0, 255)), 0);
    step(0, 8'h00, 1);
    step(1, 8'hAA, 1);
    chk("r033_ovf", {127'd0, overflow}, 128'd1);
    step(0, 8'h00, 0);
    w0 = dut_wr;
    send_seq(8'h20, 16);
    step(0, 8'h00, 0);
    chk("r033_writes", 128'(dut_wr - w0), 128'd1);
    chk("r033_dout", last_wr_dout,
        128'h202122232425262728292A2B2C2D2E2F);
    chk("r033_sticky", {127'd0, overflow}, 128'd1);

    // Timeout on a partial block
    w0 = dut_wr;
    t0 = dut_to;
    send_seq(8'h55, 5);
    repeat (T) step(0, 8'h00, 0);
    chk("r034_to_count", 128'(dut_to - t0), 128'd1);
    chk("r034_no_write", 128'(dut_wr - w0), 128'd0);
    send_seq(8'h10, 16);
    step(0, 8'h00, 0);
    chk("r034_dout", last_wr_dout,
        128'h101112131415161718191A1B1C1D1E1F);

    // Byte on the exact expiry cycle wins
    t0 = dut_to;
    send_seq(8'h30, 5);
    repeat (T - 1) step(0, 8'h00, 0);
    send_seq(8'h35, 11);
    step(0, 8'h00, 0);
    chk("r035_no_to", 128'(dut_to - t0), 128'd0);
    chk("r035_dout", last_wr_dout,
        128'h303132333435363738393A3B3C3D3E3F);

    // Async reset mid-block
    send_seq(8'hC0, 9);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_outs("r036_async");
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    w0 = dut_wr;
    send_seq(8'h40, 16);
    repeat (3) step(0, 8'h00, 0);
    chk("r036_writes", 128'(dut_wr - w0), 128'd1);
    chk("r036_dout", last_wr_dout,
        128'h404142434445464748494A4B4C4D4E4F);

    // Random traffic against the model
    for (int ph = 0; ph < 6; ph++) begin
      p = (ph % 2 == 0) ? 60 : 6;
      for (int i = 0; i < 500; i++) begin
        step(($urandom_range(0, 99) < p),
             8'($urandom_range(0, 255)),
             ($urandom_range(0, 99) < 30));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
